uart_txqueue: RTL and testbench
===============================

// Module: uart_txqueue
// PURPOSE
//   Byte FIFO and transmit sequencer between a character producer (dbgtouart or a bus-mapped
//   console write) and the uarttx serializer. The producer writes bytes at full clock rate
//   without waiting on the UART; the block drains them one at a time. It pulses txen only when
//   the serializer is idle and has acknowledged the previous byte.
// PARAMETERS
//   DEPTH         16  FIFO capacity in bytes; power of two, >= 2
//   AW            4   log2(DEPTH); pointer width
//   ACK_TIMEOUT   4   cycles to wait for txbusy to rise after a txen pulse before giving up
// PORTS
//   clk       in   1     system clock (cpuclk domain)
//   rst       in   1     asynchronous reset, active-high
//   wdata     in   8     byte from producer
//   wen       in   1     write strobe; one byte per cycle while high
//   flush     in   1     discard all queued bytes and clear overflow
//   full      out  1     level == DEPTH
//   empty     out  1     level == 0
//   level     out  AW+1  bytes currently queued, 0..DEPTH
//   overflow  out  1     sticky: a write was dropped because the queue was full
//   txchar    out  8     byte presented to uarttx (charin)
//   txen      out  1     one-cycle start pulse to uarttx
//   txbusy    in   1     uarttx busy
// BEHAVIOUR
//   Reset (async, rst=1): pointers=0, level=0, empty=1, full=0, overflow=0, txchar=8'h00, txen=0,
//     FSM=IDLE. Mid-transfer reset abandons the in-flight byte; uarttx is reset by its own reset.
//   FIFO: registered storage with wr_ptr/rd_ptr of AW bits, wrapping modulo DEPTH. level is an
//     AW+1 counter; full and empty decode from level, not from pointer compare.
//   Write: wen & !full & !flush stores wdata at wr_ptr. wr_ptr and level are updated on that edge.
//   Write when full: the write is dropped, contents are unchanged, and overflow is set.
//     Exception: a write and a pop in the same cycle with level==DEPTH is accepted, level stays DEPTH.
//   Simultaneous write and pop (level 1..DEPTH): level unchanged, both pointers advance.
//   Flush: rd_ptr=wr_ptr=0, level=0, overflow=0 on the next edge.
//     A concurrent wen is dropped and does not set overflow.
//     Flush does not abort a byte already issued; the FSM state and txchar are unaffected.
//   FSM states:
//     IDLE: if !empty & !txbusy & !flush, pop the head into txchar, txen<=1, then go to ACK.
//       txen is registered, so it is high for exactly the one cycle after the pop edge.
//     ACK: the ACK_TIMEOUT counter runs while txbusy=0.
//       txbusy=1 -> DONE.
//       Counter reaches ACK_TIMEOUT-1 with txbusy still 0 -> IDLE; the byte counts as sent.
//     DONE: wait for txbusy=0, then go to IDLE.
//       The next pop happens at the earliest on the edge after the transition to IDLE.
//   txen is never high in two consecutive cycles, and never high while the FSM is in DONE.
//   txchar holds its value from the pop until the next pop.
//   Latency: wen at edge N into an empty queue with txbusy=0 -> empty=0 after N.
//     Pop and txen=1 follow at edge N+1; txen is high during cycle N+1..N+2.
//   Ordering: strict FIFO; no byte is duplicated or skipped except by flush, overflow or reset.
// TESTING
//   1. Reset, then write 8'h41 with txbusy model idle -> txen pulses once 1 cycle later,
//      txchar=8'h41, level back to 0.
//   2. Burst-write "HELLO" (5 bytes, back-to-back) with a uarttx model at 10 cycles/byte ->
//      exactly 5 txen pulses, in order H,E,L,L,O, each after the previous busy falls; empty=1 at end.
//   3. Hold txbusy=1 and write 17 bytes with DEPTH=16 -> full=1 after 16 writes, overflow=1,
//      level=16; after release, the first 16 bytes drain and the 17th is absent.
//   4. Full queue, busy low, write on the pop cycle -> the write is accepted, level stays 16,
//      and overflow stays 0.
//   5. txbusy tied 0 (no ack): queue 2 bytes -> second txen ACK_TIMEOUT+1 cycles after the first,
//      FSM never stuck.
//   6. Flush while a byte is in DONE and 3 are queued -> level=0 next cycle, overflow cleared,
//      no further txen. Reset asserted mid-burst -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/uart_txqueue.sv
`default_nettype none
// ============================================================================
// Module      : uart_txqueue
// Description : Byte FIFO feeding a UART serializer, with a txen/txbusy
//               handshake sequencer that drains one byte at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_txqueue #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wdata,
  input  logic          wen,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    txchar,
  output logic          txen,
  input  logic          txbusy
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ACK  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam int              c_CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [AW:0]     c_LVL_FULL = (AW + 1)'(DEPTH);

  logic [7:0]          mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [1:0]          state_q, state_d;
  logic [c_CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]          txchar_q, txchar_d;
  logic                txen_q, txen_d;
  logic                w_pop;
  logic                w_wr;

  assign full     = (level_q == c_LVL_FULL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign txchar   = txchar_q;
  assign txen     = txen_q;

  // A pop frees a slot on the same edge, so a write to a full queue is still taken.
  assign w_wr = wen & ~flush & (~full | w_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (w_wr)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   level_d = level_q + (AW + 1)'(1);
        2'b01:   level_d = level_q - (AW + 1)'(1);
        default: level_d = level_q;
      endcase
      if (wen && full && !w_pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      txchar_q   <= 8'h00;
      txen_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      txchar_q   <= txchar_d;
      txen_q     <= txen_d;
      cnt_q      <= cnt_d;
    end
  end

  // Sequencer: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= c_IDLE;
    else     state_q <= state_d;
  end

  // Sequencer: next state; the ack counter only advances while txbusy stays low
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (w_pop) begin
          state_d = c_ACK;
          cnt_d   = '0;
        end
      end
      c_ACK: begin
        if (txbusy)                  state_d = c_DONE;
        else if (cnt_q == c_CNT_LAST) state_d = c_IDLE;
        else                         cnt_d   = cnt_q + c_CNT_W'(1);
      end
      c_DONE: begin
        if (!txbusy) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Sequencer: outputs
  always_comb begin
    w_pop    = (state_q == c_IDLE) & ~empty & ~txbusy & ~flush;
    txen_d   = w_pop;
    txchar_d = w_pop ? mem_q[rd_ptr_q] : txchar_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_txqueue.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_txqueue
// Description : Self-checking bench for uart_txqueue against a queue-based
//               reference model and a behavioural serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_txqueue;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TO    = 4;

  localparam int M_RESP  = 0;
  localparam int M_HOLD  = 1;
  localparam int M_NOACK = 2;
  localparam int M_RAND  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic        wen = 1'b0;
  logic        flush = 1'b0;
  logic        txbusy = 1'b0;
  logic        full, empty, overflow, txen;
  logic [AW:0] level;
  logic [7:0]  txchar;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  q[$];
  logic        ovf_m = 1'b0;
  int          pops = 0;
  int          pop_cyc[$];
  int          cyc = 0;
  int          mode = M_RESP;
  int          ucnt = 0;
  int          cyc_per = 10;
  logic        txen_prev = 1'b0;

  uart_txqueue #(.DEPTH(DEPTH), .AW(AW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .wen(wen), .flush(flush),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .txchar(txchar), .txen(txen), .txbusy(txbusy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply held inputs, then update the model and compare everything.
  task automatic step();
    logic       wen_p, flush_p, busy_p, txen_p;
    logic [7:0] wd_p, exp_b;
    int         sz;
    wen_p = wen; flush_p = flush; busy_p = txbusy; wd_p = wdata; txen_p = txen_prev;
    @(posedge clk); #1;
    cyc++;
    sz = q.size();
    if (txen) begin
      pops++;
      pop_cyc.push_back(cyc);
      check("pop_nonempty", 32'(sz > 0), 32'd1);
      check("pop_legal", 32'({busy_p, flush_p, txen_p}), 32'd0);
      if (sz > 0) begin
        exp_b = q.pop_front();
        check("txchar", 32'(txchar), 32'(exp_b));
      end
    end
    if (flush_p) begin
      q.delete();
      ovf_m = 1'b0;
    end else if (wen_p) begin
      if (sz < DEPTH || txen) q.push_back(wd_p);
      else ovf_m = 1'b1;
    end
    check("level", 32'(level), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(ovf_m));
    txen_prev = txen;
    case (mode)
      M_RESP: begin
        if (txen) ucnt = cyc_per;
        else if (ucnt > 0) ucnt--;
        txbusy = (ucnt > 0);
      end
      M_HOLD:  begin ucnt = 0; txbusy = 1'b1; end
      M_NOACK: begin ucnt = 0; txbusy = 1'b0; end
      default: begin ucnt = 0; txbusy = (($urandom % 3) == 0); end
    endcase
  endtask

  task automatic do_reset();
    wen = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_txen", 32'(txen), 32'd0);
    check("rst_txchar", 32'(txchar), 32'h00);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    q.delete(); ovf_m = 1'b0; ucnt = 0; txen_prev = 1'b0;
    txbusy = (mode == M_HOLD);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0; wen = 1'b0; flush = 1'b0; mode = M_RESP;
    while ((q.size() != 0 || ucnt != 0) && n < 3000) begin
      step();
      n++;
    end
    check(tag, 32'(n < 3000), 32'd1);
    repeat (TO + 2) step();
  endtask

  initial begin
    logic [7:0] hello [5];
    int         n1, gap;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

    mode = M_RESP; cyc_per = 3;
    do_reset();

    // single byte latency
    pops = 0; pop_cyc.delete();
    wen = 1'b1; wdata = 8'h41; step(); n1 = cyc; wen = 1'b0;
    check("t1_empty", 32'(empty), 32'd0);
    step();
    check("t1_txen", 32'(txen), 32'd1);
    check("t1_txchar", 32'(txchar), 32'h41);
    check("t1_latency", 32'(pop_cyc.size() > 0 ? pop_cyc[0] : -1), 32'(n1 + 1));
    step();
    check("t1_txen_low", 32'(txen), 32'd0);
    wait_drain("t1_drain");
    check("t1_pops", 32'(pops), 32'd1);

    // HELLO burst against a 10-cycle serializer
    cyc_per = 10; pops = 0;
    for (int i = 0; i < 5; i++) begin
      wen = 1'b1; wdata = hello[i]; step();
    end
    wait_drain("t2_drain");
    check("t2_pops", 32'(pops), 32'd5);
    check("t2_empty", 32'(empty), 32'd1);

    // overfill while the serializer is held busy
    mode = M_HOLD; txbusy = 1'b1; pops = 0;
    for (int i = 0; i < 17; i++) begin
      wen = 1'b1; wdata = 8'($urandom); step();
      if (i == 15) check("t3_full16", 32'(full), 32'd1);
    end
    wen = 1'b0;
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_level", 32'(level), 32'd16);
    wait_drain("t3_drain");
    check("t3_pops", 32'(pops), 32'd16);

    // write on the pop cycle of a full queue
    flush = 1'b1; step(); flush = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    mode = M_HOLD; txbusy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wen = 1'b1; wdata = 8'($urandom); step();
    end
    mode = M_RESP; ucnt = 0; txbusy = 1'b0; wdata = 8'hA5; step(); wen = 1'b0;
    check("t4_pop", 32'(txen), 32'd1);
    check("t4_level", 32'(level), 32'd16);
    check("t4_overflow", 32'(overflow), 32'd0);
    wait_drain("t4_drain");

    // no acknowledge: ack timeout spacing
    mode = M_NOACK; txbusy = 1'b0; pops = 0; pop_cyc.delete();
    wen = 1'b1; wdata = 8'h31; step();
    wdata = 8'h32; step(); wen = 1'b0;
    repeat (3 * TO + 4) step();
    gap = (pop_cyc.size() >= 2) ? pop_cyc[1] - pop_cyc[0] : -1;
    check("t5_pops", 32'(pops), 32'd2);
    check("t5_gap", 32'(gap), 32'(TO + 1));
    wen = 1'b1; wdata = 8'h33; step(); wen = 1'b0;
    repeat (TO + 2) step();
    check("t5_not_stuck", 32'(pops), 32'd3);

    // flush while a byte is in flight and three are queued
    mode = M_RESP; cyc_per = 10;
    wait_drain("t6_pre_drain");
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; wdata = 8'(8'h60 + i); step();
    end
    wen = 1'b0;
    check("t6_level3", 32'(level), 32'd3);
    flush = 1'b1; step(); flush = 1'b0;
    check("t6_flush_level", 32'(level), 32'd0);
    check("t6_flush_ovf", 32'(overflow), 32'd0);
    pops = 0;
    repeat (30) step();
    check("t6_no_txen", 32'(pops), 32'd0);

    // reset in the middle of a burst
    for (int i = 0; i < 6; i++) begin
      wen = 1'b1; wdata = 8'($urandom); step();
      if (i == 3) break;
    end
    do_reset();
    wait_drain("t6_post_reset_drain");

    // randomized traffic under several serializer behaviours
    for (int seg = 0; seg < 3; seg++) begin
      mode = (seg == 0) ? M_RESP : (seg == 1) ? M_RAND : M_NOACK;
      cyc_per = $urandom_range(1, 12);
      for (int i = 0; i < 600; i++) begin
        wen   = ($urandom % 100) < 55;
        wdata = 8'($urandom);
        flush = ($urandom % 100) < 2;
        step();
      end
    end
    wait_drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
